// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, signed or unsigned,
// with divide-by-zero short-circuit and back-to-back start from the DONE cycle.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             dbz
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo, dvs;
  logic             qneg, rneg;
  logic             accept;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   shifted, trial, rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             qbit;

  assign ready  = (state != BUSY);
  assign done   = (state == DONE);
  assign accept = start & ready;
  assign mag1   = (sgn & in1[WIDTH-1]) ? -in1 : in1;
  assign mag2   = (sgn & in2[WIDTH-1]) ? -in2 : in2;

  // One restoring step; rem[WIDTH] set means the shifted value surely covers dvs.
  always_comb begin
    shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    qbit    = rem[WIDTH] | (shifted >= {1'b0, dvs});
    rem_nx  = qbit ? trial : shifted;
    quo_nx  = {quo[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      a     <= '0;
      b     <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            quo  <= mag1;
            dvs  <= mag2;
            rem  <= '0;
            qneg <= sgn & (in1[WIDTH-1] ^ in2[WIDTH-1]);
            rneg <= sgn & in1[WIDTH-1];
            if (in2 == '0) begin
              a     <= '1;
              b     <= in1;
              dbz   <= 1'b1;
              state <= DONE;
            end else begin
              cnt   <= CW'(WIDTH);
              state <= BUSY;
            end
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            // Sign fix-up on the last step; most-negative / -1 wraps to itself.
            a     <= qneg ? -quo_nx : quo_nx;
            b     <= rneg ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
            dbz   <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=16): vector table plus hand-written
// back-to-back, start-during-busy and mid-operation reset sequences.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk, rst, start, sgn;
  logic [W-1:0] in1, in2, a, b;
  logic         ready, done, dbz;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .in1(in1), .in2(in2),
    .ready(ready), .done(done), .a(a), .b(b), .dbz(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         s;
    logic [W-1:0] x, y, ea, eb;
    logic         ez;
  } vec_t;

  vec_t vt[14];
  int   total = 0, passed = 0;
  int   lat, nrdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // now=1 drives start in the current (DONE) cycle; poke>0 pulses start with
  // unrelated operands at that cycle of the operation.
  task automatic do_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit now, input int poke);
    if (!now) @(negedge clk);
    sgn = s; in1 = x; in2 = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; in1 = W'($urandom); in2 = W'($urandom); sgn = 1'b0;
    lat = 0; nrdy = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (!ready) nrdy++;
      if (done) break;
      if (lat == poke) begin
        start = 1'b1; sgn = 1'b0; in1 = 16'd9; in2 = 16'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    logic [W-1:0] held;
    int seen;
    vt = '{
      '{1'b0, 16'd8,    16'd3,    16'd2,    16'd2,    1'b0},
      '{1'b0, 16'd15,   16'd7,    16'd2,    16'd1,    1'b0},
      '{1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0},
      '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0},
      '{1'b0, 16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b1},
      '{1'b1, 16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b1},
      '{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0},
      '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0},
      '{1'b0, 16'h1234, 16'h5678, 16'h0000, 16'h1234, 1'b0},
      '{1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0},
      '{1'b1, 16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0},
      '{1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0},
      '{1'b1, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0},
      '{1'b0, 16'd100,  16'd9,    16'd11,   16'd1,    1'b0}
    };

    rst = 1'b1; start = 1'b0; sgn = 1'b0; in1 = '0; in2 = '0;
    #12;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_a",     {16'd0, a},     32'd0);
    chk("rst_b",     {16'd0, b},     32'd0);
    chk("rst_dbz",   {31'd0, dbz},   32'd0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      do_op(vt[i].s, vt[i].x, vt[i].y, 1'b0, 0);
      chk($sformatf("v%0d_a", i),   {16'd0, a},   {16'd0, vt[i].ea});
      chk($sformatf("v%0d_b", i),   {16'd0, b},   {16'd0, vt[i].eb});
      chk($sformatf("v%0d_dbz", i), {31'd0, dbz}, {31'd0, vt[i].ez});
      chk($sformatf("v%0d_lat", i), 32'(lat), (vt[i].y == 0) ? 32'd1 : 32'd17);
      if (vt[i].y != 0) chk($sformatf("v%0d_busy", i), 32'(nrdy), 32'd16);
      held = a;
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), {31'd0, done}, 32'd0);
      chk($sformatf("v%0d_hold", i),  {16'd0, a},    {16'd0, held});
    end

    // Back-to-back: second start in the DONE cycle of the first.
    do_op(1'b0, 16'd8, 16'd3, 1'b0, 0);
    chk("b2b_first_a", {16'd0, a}, 32'd2);
    do_op(1'b0, 16'd15, 16'd7, 1'b1, 0);
    chk("b2b_lat", 32'(lat), 32'd17);
    chk("b2b_a",   {16'd0, a}, 32'd2);
    chk("b2b_b",   {16'd0, b}, 32'd1);

    // start pulsed while busy must not disturb 1000/7.
    do_op(1'b0, 16'd1000, 16'd7, 1'b0, 5);
    chk("poke_lat", 32'(lat), 32'd17);
    chk("poke_a",   {16'd0, a}, 32'd142);
    chk("poke_b",   {16'd0, b}, 32'd6);
    @(negedge clk);
    chk("poke_idle", {31'd0, done}, 32'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    sgn = 1'b0; in1 = 16'd50000; in2 = 16'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_busy", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_ready", {31'd0, ready}, 32'd1);
    chk("mid_done",  {31'd0, done},  32'd0);
    chk("mid_a",     {16'd0, a},     32'd0);
    chk("mid_b",     {16'd0, b},     32'd0);
    chk("mid_dbz",   {31'd0, dbz},   32'd0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("mid_nodone", 32'(seen), 32'd0);
    do_op(1'b0, 16'd100, 16'd9, 1'b0, 0);
    chk("post_lat", 32'(lat), 32'd17);
    chk("post_a",   {16'd0, a}, 32'd11);
    chk("post_b",   {16'd0, b}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The module SHALL have the parameter WIDTH, default 16, giving the operand and result width in bits (legal range 2..32).
REQ-002 The port clk SHALL be an input of width 1: the single clock; all state updates occur on its rising edge.
REQ-003 The port rst SHALL be an input of width 1: an asynchronous, active-high reset.
REQ-004 The port start SHALL be an input of width 1: the request to begin a division; it is sampled only when ready=1.
REQ-005 The port sgn SHALL be an input of width 1: 0 selects an unsigned operation, 1 selects two's-complement signed; it is sampled with start.
REQ-006 The port in1 SHALL be an input of width WIDTH: the dividend, sampled with start.
REQ-007 The port in2 SHALL be an input of width WIDTH: the divisor, sampled with start.
REQ-008 The port ready SHALL be an output of width 1: 1 when a start will be accepted.
REQ-009 The port done SHALL be an output of width 1: a one-cycle pulse indicating that the results are valid.
REQ-010 The port a SHALL be an output of width WIDTH: the quotient.
REQ-011 The port b SHALL be an output of width WIDTH: the remainder.
REQ-012 The port dbz SHALL be an output of width 1: the divide-by-zero flag for the last completed operation.

Function
REQ-013 The state machine SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 ready SHALL be 1 in IDLE and DONE, and 0 in BUSY.
REQ-015 On start=1 with ready=1, the block SHALL latch in1, in2 and sgn, then move to BUSY with a step counter of WIDTH; if in2=0 it SHALL move directly to DONE instead.
REQ-016 In signed mode, the operand magnitudes SHALL be used internally, and the result signs recorded as: quotient negative iff the operand signs differ; remainder sign follows the dividend.
REQ-017 In BUSY, each cycle SHALL perform one restoring shift-subtract step on a (WIDTH+1)-bit partial remainder and decrement the counter; after WIDTH steps the state SHALL be DONE.
REQ-018 Latency: done SHALL assert exactly WIDTH+1 cycles after the accepting edge (1 cycle for divide-by-zero).
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, with a, b and dbz updated in that same cycle.
REQ-020 a, b and dbz SHALL then hold until the next DONE.
REQ-021 Leaving DONE, the state SHALL be IDLE, or BUSY/DONE if start=1 is accepted in the DONE cycle, giving back-to-back operation.
REQ-022 The results SHALL satisfy in1 = a*in2 + b, with |b| < |in2|, and quotient truncation toward zero.
REQ-023 Signed overflow (most negative value / -1) SHALL give a = most negative value, b = 0, dbz = 0.
REQ-024 Divide-by-zero SHALL give a = all ones, b = in1, and dbz = 1, in either mode.
REQ-025 start while in BUSY SHALL be ignored, with no effect on the operation in flight.
REQ-026 Operand inputs SHALL be don't-care outside the accepting cycle.

Reset
REQ-027 While rst=1, the state SHALL be IDLE and the outputs SHALL be ready=1, done=0, a=0, b=0, dbz=0, with the counter and internal registers cleared.
REQ-028 rst asserted mid-operation SHALL abort the operation immediately: no done pulse is produced, and the first start after release starts a fresh operation.

Verification (WIDTH=16)
REQ-029 Scenario: unsigned in1=8, in2=3, start -> done at accept+17 cycles, a=2, b=2, dbz=0; ready=0 for 16 cycles.
REQ-030 Scenario: back-to-back: 15/7 started in the DONE cycle of the previous operation -> a=2, b=1, 17 cycles later, with no idle gap.
REQ-031 Scenario: signed -7/2 (0xFFF9/0x0002) -> a=0xFFFD, b=0xFFFF; signed 0x8000/0xFFFF -> a=0x8000, b=0, dbz=0.
REQ-032 Scenario: in1=5, in2=0 (both modes) -> done one cycle after accept, a=0xFFFF, b=5, dbz=1.
REQ-033 Scenario: start=1 pulsed during BUSY with different operands -> ignored; the original results are reported.
REQ-034 Scenario: rst at BUSY step 8 -> outputs 0 immediately, ready=1, no done; a following 100/9 -> a=11, b=1.
